rf_tx_burst_buffer: RTL and testbench
=====================================

RF_TX_BURST_BUFFER -- requirements
Module: rf_tx_burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of buffered data.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 512: FIFO entries, power of two, at least 4.
REQ-003 SHALL have parameter START_THRESHOLD, default 58: fill level, 1..BUFFER_DEPTH, that starts a burst.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 16276: cycles with no input, at least 1, after which a partial buffer is sent.
REQ-005 SHALL have port internal_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: one-cycle pulse marking a received MCU byte.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: byte sampled when in_valid=1.
REQ-009 SHALL have port out_valid, output, 1 bit: a byte is offered to the node-side UART.
REQ-010 SHALL have port out_ready, input, 1 bit: node UART accepts the offered byte.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: byte at the FIFO head.
REQ-012 SHALL have port tx_enable, input, 1 bit: wireless transmission permitted, driven by mode/state control.
REQ-013 SHALL have port flush, input, 1 bit: discard all buffered data.
REQ-014 SHALL have port ovf_clear, input, 1 bit: clear the overflow status.
REQ-015 SHALL have port aux, output, 1 bit: 1 = idle and empty, 0 = busy.
REQ-016 SHALL have port level, output, $clog2(BUFFER_DEPTH)+1 bits: current occupancy.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-018 SHALL have port drop_count, output, 8 bits: saturating count of dropped bytes.

Function
REQ-019 SHALL implement a circular FIFO with first-word fall-through: out_data = head entry whenever level>0.
REQ-020 SHALL perform a push on any cycle with in_valid=1 and level<BUFFER_DEPTH; the pushed byte SHALL be reflected in level on the next cycle.
REQ-021 SHALL perform a pop on any cycle with out_valid=1 and out_ready=1.
REQ-022 SHALL, when full and a push and a pop coincide, accept both, leaving level unchanged.
REQ-023 SHALL, when full with in_valid=1 and no pop, drop the byte, set overflow=1, and increment drop_count, saturating at 255.
REQ-024 SHALL wrap the read and write pointers modulo BUFFER_DEPTH.
REQ-025 SHALL implement FSM state IDLE (level=0).
REQ-026 SHALL implement FSM state COLLECT (level>0, not sending).
REQ-027 SHALL implement FSM state SEND (draining).
REQ-028 SHALL transition IDLE->COLLECT on a push.
REQ-029 SHALL transition COLLECT->SEND when tx_enable=1 and either level>=START_THRESHOLD or idle_timer>=IDLE_TIMEOUT.
REQ-030 SHALL transition SEND->IDLE when level=0 and no push occurs that cycle.
REQ-031 SHALL transition any state->IDLE on flush=1.
REQ-032 SHALL reload idle_timer to 0 on every push and SHALL increment it in COLLECT otherwise, saturating at IDLE_TIMEOUT; idle_timer is held at 0 in IDLE and SEND.
REQ-033 SHALL drive out_valid = (state==SEND) & tx_enable & (level>0); out_valid is 0 in IDLE and COLLECT.
REQ-034 SHALL, on tx_enable falling in SEND, stay in SEND with out_valid=0 and resume when tx_enable returns; no byte is lost or duplicated.
REQ-035 SHALL, in SEND, accept pushes and transmit them in the same burst (order preserved).
REQ-036 SHALL, on flush=1, reset pointers and level to 0 the next cycle, with no pop that cycle; a simultaneous in_valid byte is discarded without counting as a drop.
REQ-037 SHALL leave overflow and drop_count unchanged on flush.
REQ-038 SHALL clear overflow and drop_count on ovf_clear=1; a drop in the same cycle SHALL win (overflow=1, drop_count=1).
REQ-039 SHALL drive aux as a registered output: aux = 1 only in IDLE with level=0, and aux falls the cycle after the first push.

Reset
REQ-040 SHALL, on rst=1 at a clock edge, force state=IDLE, pointers=0, level=0, idle_timer=0, overflow=0, drop_count=0, aux=1, out_valid=0.
REQ-041 SHALL give rst priority over flush, push and pop; reset mid-burst discards all contents, and the FIFO memory itself needs no reset.

Verification
REQ-042 Scenario threshold: 58 pushes, tx_enable=1, out_ready=1 -> SEND entered the cycle after level=58; 58 bytes out in order; aux returns to 1 after drain.
REQ-043 Scenario timeout: 3 pushes then silence, IDLE_TIMEOUT=16276 -> no out_valid until 16276 idle cycles have elapsed, then 3 bytes out.
REQ-044 Scenario overflow: 514 pushes with tx_enable=0 -> level=512, overflow=1, drop_count=2; ovf_clear -> 0/0.
REQ-045 Scenario back-pressure: in SEND, toggle out_ready and tx_enable each 3 cycles -> output sequence identical to input, no duplicates.
REQ-046 Scenario flush/reset: flush at level=20, then rst mid-burst -> level=0, state IDLE, aux=1 the next cycle.
REQ-047 Scenario full simultaneous push/pop: level=512 in SEND with push and pop together -> level stays 512, overflow stays 0.

Source files
------------

// File: rtl/rf_tx_burst_buffer.sv
// rtl/rf_tx_burst_buffer.sv - burst-forming TX byte buffer between MCU UART and node UART
// Collects bytes in a FWFT FIFO and releases them as a burst on fill threshold or idle timeout.
module rf_tx_burst_buffer #(
  parameter int DATA_WIDTH      = 8,
  parameter int BUFFER_DEPTH    = 512,
  parameter int START_THRESHOLD = 58,
  parameter int IDLE_TIMEOUT    = 16276
) (
  input  logic                            internal_clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  input  logic                            tx_enable,
  input  logic                            flush,
  input  logic                            ovf_clear,
  output logic                            aux,
  output logic [$clog2(BUFFER_DEPTH):0]   level,
  output logic                            overflow,
  output logic [7:0]                      drop_count
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drops_q, drops_d;
  logic            aux_q, aux_d;

  logic [DATA_WIDTH-1:0] fifo_mem [BUFFER_DEPTH];

  logic full, push, pop, drop;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  always_comb begin
    full      = (level_q == LW'(BUFFER_DEPTH));
    out_valid = (state_q == S_SEND) && tx_enable && (level_q != '0);
    pop       = out_valid && out_ready && !flush;
    push      = in_valid && !flush && (!full || pop);
    drop      = in_valid && !flush && full && !pop;
    out_data  = fifo_mem[rptr_q];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // A drop coinciding with ovf_clear restarts the count at one.
  always_comb begin
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clear)              drops_d = 8'd1;
      else if (drops_q != 8'hff)  drops_d = drops_q + 8'd1;
    end else if (ovf_clear) begin
      ovf_d   = 1'b0;
      drops_d = 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      S_IDLE:    if (push) state_d = S_COLLECT;
      S_COLLECT: if (tx_enable && ((level_q >= LW'(START_THRESHOLD)) ||
                                   (timer_q >= TW'(IDLE_TIMEOUT))))
                   state_d = S_SEND;
      S_SEND:    if ((level_q == '0) && !push) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;

    if (state_q == S_COLLECT && !push && !flush)
      timer_d = (timer_q >= TW'(IDLE_TIMEOUT)) ? timer_q : timer_q + TW'(1);

    aux_d = (state_d == S_IDLE) && (level_d == '0);
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      drops_q <= 8'd0;
      aux_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
      aux_q   <= aux_d;
    end
  end

  always_ff @(posedge internal_clk) begin
    if (push && !rst) fifo_mem[wptr_q] <= in_data;
  end

  assign aux        = aux_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drops_q;

endmodule

// File: tb/tb_rf_tx_burst_buffer.sv
// tb/tb_rf_tx_burst_buffer.sv - self-checking bench for rf_tx_burst_buffer
// Queue-based reference model, directed scenarios and a randomized phase.
module tb_rf_tx_burst_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 512;
  localparam int THR   = 58;
  localparam int TMO   = 16276;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_valid, out_ready, tx_enable, flush, ovf_clear;
  logic          aux, overflow;
  logic [DW-1:0] in_data, out_data;
  logic [9:0]    level;
  logic [7:0]    drop_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_tx_burst_buffer #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .START_THRESHOLD(THR), .IDLE_TIMEOUT(TMO)
  ) dut (
    .internal_clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tx_enable(tx_enable), .flush(flush), .ovf_clear(ovf_clear), .aux(aux),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  // Reference model: byte queue plus a "bursting" flag and a quiet-cycle count.
  logic [DW-1:0] mq[$];
  bit            m_send  = 0;
  int            m_quiet = 0;
  bit            m_ovf   = 0;
  int            m_drops = 0;
  bit            m_aux   = 1;
  bit            chk_en  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    bit ev, take, acc, drp, full, coll;
    int sz;
    @(negedge clk);
    sz = mq.size();
    ev = m_send && tx_enable && (sz > 0);
    if (chk_en) begin
      check_eq("out_valid", 32'(out_valid), 32'(ev));
      if (ev) check_eq("out_data", 32'(out_data), 32'(mq[0]));
      check_eq("level", 32'(level), 32'(sz));
      check_eq("aux", 32'(aux), 32'(m_aux));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("drop_count", 32'(drop_count), 32'(m_drops));
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_send = 0; m_quiet = 0; m_ovf = 0; m_drops = 0; m_aux = 1;
      chk_en = 1;
    end else begin
      full = (sz == DEPTH);
      take = ev && out_ready && !flush;
      acc  = in_valid && !flush && (!full || take);
      drp  = in_valid && !flush && full && !take;
      coll = !m_send && (sz > 0);
      if (drp) begin
        m_ovf   = 1;
        m_drops = ovf_clear ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (ovf_clear) begin
        m_ovf = 0; m_drops = 0;
      end
      if (flush) begin
        mq.delete();
        m_send = 0; m_quiet = 0;
      end else begin
        if (coll && tx_enable && (sz >= THR || m_quiet >= TMO)) m_send = 1;
        else if (m_send && sz == 0 && !acc) m_send = 0;
        m_quiet = acc ? 0 : (coll ? ((m_quiet < TMO) ? m_quiet + 1 : TMO) : 0);
        if (take) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
      m_aux = !m_send && (mq.size() == 0);
    end
    #1;
  endtask

  task automatic cyc(input bit iv, input bit rdy, input bit txe);
    in_valid  = iv;
    in_data   = 8'($urandom);
    out_ready = rdy;
    tx_enable = txe;
    flush     = 0;
    ovf_clear = 0;
    rst       = 0;
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (aux !== 1'b1 && n < TMO + 2000) begin
      cyc(0, 1, 1);
      n++;
    end
    check_eq(tag, 32'(aux), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] drops_before;

    rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
    tx_enable = 0; flush = 0; ovf_clear = 0;
    tick();
    tick();
    rst = 0;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_aux", 32'(aux), 32'd1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);

    // Threshold-triggered burst
    cyc(1, 1, 1);
    check_eq("aux_fall", 32'(aux), 32'd0);
    for (int i = 1; i < THR; i++) cyc(1, 1, 1);
    check_eq("thr_level", 32'(level), 32'(THR));
    check_eq("thr_pre_valid", 32'(out_valid), 32'd0);
    cyc(0, 1, 1);
    check_eq("thr_send", 32'(out_valid), 32'd1);
    drain("thr_drain");

    // Idle-timeout burst of a partial buffer
    for (int i = 0; i < 3; i++) cyc(1, 1, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < TMO + 100) begin
      cyc(0, 1, 1);
      n++;
    end
    check_eq("tmo_latency", 32'(n), 32'(TMO + 1));
    drain("tmo_drain");

    // Overflow, saturation and ovf_clear precedence
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 1, 0);
    check_eq("ovf_level", 32'(level), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 258; i++) cyc(1, 1, 0);
    check_eq("ovf_sat", 32'(drop_count), 32'd255);
    in_valid = 0; ovf_clear = 1; tick(); ovf_clear = 0;
    check_eq("clr_flag", 32'(overflow), 32'd0);
    check_eq("clr_drops", 32'(drop_count), 32'd0);
    in_valid = 1; ovf_clear = 1; tick(); ovf_clear = 0; in_valid = 0;
    check_eq("clr_race_flag", 32'(overflow), 32'd1);
    check_eq("clr_race_drops", 32'(drop_count), 32'd1);
    ovf_clear = 1; tick(); ovf_clear = 0;
    check_eq("clr2_drops", 32'(drop_count), 32'd0);

    // Full buffer with simultaneous push and pop
    cyc(0, 1, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1);
    check_eq("full_pp_level", 32'(level), 32'(DEPTH));
    check_eq("full_pp_ovf", 32'(overflow), 32'd0);
    drain("full_drain");

    // Back-pressure: out_ready and tx_enable toggling in SEND
    for (int i = 0; i < THR + 2; i++) cyc(1, 1, 1);
    for (int i = 0; i < 150; i++)
      cyc(1'($urandom_range(0, 1)), ((i / 3) % 2) == 0, ((i / 6) % 2) == 0);
    drain("bp_drain");

    // Flush at level 20, then reset mid-burst
    for (int i = 0; i < 20; i++) cyc(1, 1, 0);
    check_eq("fl_level_pre", 32'(level), 32'd20);
    drops_before = drop_count;
    in_valid = 1; flush = 1; tick(); flush = 0; in_valid = 0;
    check_eq("fl_level", 32'(level), 32'd0);
    check_eq("fl_aux", 32'(aux), 32'd1);
    check_eq("fl_drops", 32'(drop_count), 32'(drops_before));
    for (int i = 0; i < 80; i++) cyc(1, 1, 1);
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    rst = 1; tick(); rst = 0;
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_aux", 32'(aux), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 50);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      tx_enable = ($urandom_range(0, 99) < 85);
      flush     = ($urandom_range(0, 999) < 8);
      ovf_clear = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 0; flush = 0; ovf_clear = 0;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
